// File: rtl/serial_frame_deser_pkg.sv
// Shared types and constants for the serial frame deserialiser.
// The default sync pattern is stored with its first-received bit in the MSB.
package serial_deser_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int             SYNC_W_DEF   = 4;
   localparam logic [3:0]     SYNC_PAT_DEF = 4'b1011;
   localparam int             FRAME_CNT_W  = 8;

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input, parallel valid/ready output and status bundle of the deserialiser.
// The slave modport is the deserialiser's view; the master modport is the source/sink side.
interface serial_frame_deser_if #(
   parameter int DATA_W = 8
) ();

   logic                                    din;
   logic                                    din_vld;
   logic [DATA_W-1:0]                       dout;
   logic                                    dout_vld;
   logic                                    dout_rdy;
   logic                                    sync_lock;
   logic                                    overrun;
   logic [serial_deser_pkg::FRAME_CNT_W-1:0] frame_cnt;

   modport slave (
      input  din, din_vld, dout_rdy,
      output dout, dout_vld, sync_lock, overrun, frame_cnt
   );

   modport master (
      output din, din_vld, dout_rdy,
      input  dout, dout_vld, sync_lock, overrun, frame_cnt
   );

endinterface

// File: rtl/serial_frame_deser_out_slot.sv
// One-entry valid/ready holding register for completed words.
// A load into a full slot that is not being drained on the same edge is reported as a drop.
module deser_out_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              rdy,
   output logic              vld,
   output logic [DATA_W-1:0] data,
   output logic              full_drop
);

   logic              w_free;
   logic              r_vld;
   logic [DATA_W-1:0] r_data;

   // Slot accepts a new word when empty or when the held word leaves this edge.
   assign w_free    = ~r_vld | rdy;
   assign full_drop = load & ~w_free;

   // Holding register: load wins over drain so accept-and-load has no bubble.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else if (load && w_free) begin
         r_vld  <= 1'b1;
         r_data <= load_data;
      end else if (r_vld && rdy) begin
         r_vld  <= 1'b0;
      end else begin
         r_vld  <= r_vld;
      end
   end

   assign vld  = r_vld;
   assign data = r_data;

endmodule

// File: rtl/serial_frame_deser.sv
// Sync-hunting serial-to-parallel deserialiser: finds SYNC_PAT in the qualified bit
// stream, captures the next DATA_W bits MSB-first and hands them to a one-entry output slot.
module serial_frame_deser
   import serial_deser_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
   input logic                  clk,
   input logic                  rst,
   serial_frame_deser_if.slave  bus
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // Only the SYNC_W-1 / DATA_W-1 most recent bits are kept; the incoming bit completes them.
   state_t                   r_state;
   logic [SYNC_W-2:0]        r_window;
   logic [DATA_W-2:0]        r_shreg;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_sync_lock;
   logic                     r_overrun;
   logic [FRAME_CNT_W-1:0]   r_frame_cnt;

   logic [SYNC_W-1:0]        w_win_next;
   logic [DATA_W-1:0]        w_frame;
   logic                     w_last;
   logic                     w_load;
   logic                     w_full_drop;
   logic                     w_accept;
   logic                     w_slot_vld;
   logic [DATA_W-1:0]        w_slot_data;

   assign w_win_next = {r_window, bus.din};
   assign w_frame    = {r_shreg, bus.din};
   assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));
   assign w_load     = bus.din_vld && (r_state == SHIFT) && w_last;
   assign w_accept   = w_load & ~w_full_drop;

   // Framing FSM with sync window, payload shifter and status registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= HUNT;
         r_window    <= '0;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_sync_lock <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (bus.din_vld) begin
            case (r_state)
               HUNT: begin
                  if (w_win_next == SYNC_PAT) begin
                     r_state     <= SHIFT;
                     r_cnt       <= '0;
                     r_window    <= '0;
                     r_sync_lock <= 1'b1;
                  end else begin
                     r_window    <= w_win_next[SYNC_W-2:0];
                  end
               end
               SHIFT: begin
                  r_shreg <= w_frame[DATA_W-2:0];
                  if (w_last) begin
                     // Each frame needs a fresh sync, so the window restarts empty.
                     r_state     <= HUNT;
                     r_cnt       <= '0;
                     r_window    <= '0;
                     r_sync_lock <= 1'b0;
                  end else begin
                     r_cnt       <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state     <= HUNT;
                  r_cnt       <= '0;
                  r_window    <= '0;
                  r_sync_lock <= 1'b0;
               end
            endcase
         end
         if (w_full_drop) begin
            r_overrun <= 1'b1;
         end
         if (w_accept) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end
      end
   end

   deser_out_slot #(
      .DATA_W (DATA_W)
   ) u_out_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_data (w_frame),
      .rdy       (bus.dout_rdy),
      .vld       (w_slot_vld),
      .data      (w_slot_data),
      .full_drop (w_full_drop)
   );

   assign bus.dout      = w_slot_data;
   assign bus.dout_vld  = w_slot_vld;
   assign bus.sync_lock = r_sync_lock;
   assign bus.overrun   = r_overrun;
   assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Randomised scoreboard bench for serial_frame_deser: a bit-list reference model
// predicts words and status, a negedge monitor compares against the DUT.
module tb_serial_frame_deser;

   localparam int         DATA_W   = 8;
   localparam int         SYNC_W   = 4;
   localparam logic [3:0] SYNC_PAT = 4'b1011;

   logic clk;
   logic rst;

   serial_frame_deser_if #(.DATA_W(DATA_W)) bus ();

   serial_frame_deser dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model state, expressed as bit lists and a held-word flag.
   bit           hist[$];
   bit           pay[$];
   bit           locked;
   logic [7:0]   exp_q[$];
   logic         m_vld;
   logic [7:0]   m_dout;
   logic         m_lock;
   logic         m_ovr;
   logic [7:0]   m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tail_val();
      int v = 0;
      for (int i = hist.size() - SYNC_W; i < hist.size(); i++) v = v * 2 + int'(hist[i]);
      return v;
   endfunction

   task automatic model_step(input logic b, input logic v, input logic r, input logic rs);
      bit         done;
      logic [7:0] word;
      done = 1'b0;
      word = 8'h00;
      if (!rs) begin
         locked = 1'b0; hist.delete(); pay.delete(); exp_q.delete();
         m_vld = 1'b0; m_dout = 8'h00; m_lock = 1'b0; m_ovr = 1'b0; m_cnt = 8'h00;
         return;
      end
      if (v) begin
         if (!locked) begin
            hist.push_back(b);
            if (hist.size() > SYNC_W) void'(hist.pop_front());
            if (hist.size() == SYNC_W && tail_val() == int'(SYNC_PAT)) begin
               locked = 1'b1;
               hist.delete();
            end
         end else begin
            pay.push_back(b);
            if (pay.size() == DATA_W) begin
               for (int i = 0; i < DATA_W; i++) word = {word[6:0], pay[i]};
               pay.delete();
               locked = 1'b0;
               done = 1'b1;
            end
         end
      end
      if (done) begin
         if (!m_vld || r) begin
            m_dout = word; m_vld = 1'b1; m_cnt = m_cnt + 8'd1;
            exp_q.push_back(word);
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_vld && r) begin
         m_vld = 1'b0;
      end
      m_lock = locked;
   endtask

   task automatic cycle(input logic b, input logic v, input logic r);
      bus.din = b; bus.din_vld = v; bus.dout_rdy = r;
      @(posedge clk);
      model_step(b, v, r, rst);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      rst = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] word, input bit gap, input logic rdy_body, input logic rdy_last);
      logic [11:0] bits;
      bits = {SYNC_PAT, word};
      for (int i = 11; i >= 0; i--) begin
         if (gap) cycle(1'($urandom_range(0, 1)), 1'b0, rdy_body);
         cycle(bits[i], 1'b1, (i == 0) ? rdy_last : rdy_body);
      end
   endtask

   // Monitor: per-cycle status check plus scoreboard pop on every output transfer.
   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("dout_vld", 32'(bus.dout_vld), 32'(m_vld));
         chk("dout", 32'(bus.dout), 32'(m_dout));
         chk("sync_lock", 32'(bus.sync_lock), 32'(m_lock));
         chk("overrun", 32'(bus.overrun), 32'(m_ovr));
         chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
         if (bus.dout_vld && bus.dout_rdy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL scoreboard: transfer of 0x%0h with no expected word at %0t", bus.dout, $time);
            end else begin
               chk("sb_word", 32'(bus.dout), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [5:0] fs;
      rst = 1'b0; bus.din = 1'b0; bus.din_vld = 1'b0; bus.dout_rdy = 1'b0;
      fs = 6'b101011;

      do_reset(2);
      chk_en = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

      // Basic and gapped frames.
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

      // Backpressure and overrun, then release.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("held_3c", 32'(bus.dout), 32'h3C);
      chk("overrun_set", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

      // Accept and load on the same edge.
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      chk("b2b_vld", 32'(bus.dout_vld), 32'd1);
      chk("b2b_dout", 32'(bus.dout), 32'h22);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);

      // Held word plus partial frame, then reset mid-frame.
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) cycle(SYNC_PAT[i], 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      do_reset(1);
      chk("mid_rst_vld", 32'(bus.dout_vld), 32'd0);
      chk("mid_rst_lock", 32'(bus.sync_lock), 32'd0);

      // False sync prefix 1,0,1,0,1,1 then a payload.
      for (int i = 5; i >= 0; i--) cycle(fs[i], 1'b1, 1'b1);
      for (int i = 0; i < DATA_W; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);

      // Fully random traffic with random qualifier and backpressure.
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

      // 256 delivered frames wrap the counter.
      do_reset(2);
      for (int f = 0; f < 256; f++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("frame_cnt_wrap", 32'(bus.frame_cnt), 32'd0);

      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_frame_deser.md
Name: serial_frame_deser

Overview:
- Downstream consumer of the single-bit registered data stream produced by the reset-able D flip-flop stage.
- Hunts the bit stream for a sync pattern, then deserialises the next DATA_W bits MSB-first into a parallel word.
- Presents each word on a valid/ready output with a one-entry holding register.
- Reports lock, a sticky overrun flag and a delivered-frame counter.

Parameters:
- DATA_W, 8, payload bits per frame (2..32)
- SYNC_W, 4, sync pattern length in bits (2..8)
- SYNC_PAT, 4'b1011, sync pattern, first-received bit in MSB

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
- din  input  1  serial data bit (q of the upstream flop stage)
- din_vld  input  1  din qualifier; a bit is consumed only on cycles where din_vld=1
- dout  output  DATA_W  deserialised payload, first-received bit in MSB
- dout_vld  output  1  dout holds a valid word
- dout_rdy  input  1  downstream accepts; transfer when dout_vld & dout_rdy
- sync_lock  output  1  high while in SHIFT state
- overrun  output  1  sticky: a completed frame was dropped because the output register was full
- frame_cnt  output  8  count of frames loaded into dout, wraps 255->0

Behaviour:
- Reset (rst=0 at a posedge):
  - state=HUNT; sync window, shift register and bit counter cleared.
  - dout=0, dout_vld=0, sync_lock=0, overrun=0, frame_cnt=0.
  - Reset applies mid-frame and discards any held word.
- States: HUNT, SHIFT. Only din_vld=1 cycles advance either state; din_vld=0 freezes the window, shift register and counter.
- HUNT:
  - On each valid bit: window <= {window[SYNC_W-2:0], din}.
  - If the new window value equals SYNC_PAT: go to SHIFT, bit counter=0, window cleared.
  - Overlapping patterns are allowed; a match is checked on every valid bit.
- SHIFT:
  - On each valid bit: shreg <= {shreg[DATA_W-2:0], din}; counter increments.
  - The bit that brings the count to DATA_W completes the frame. On that same edge:
    - state returns to HUNT and the window is cleared, so each frame needs a fresh sync.
    - Output slot free (dout_vld=0, or dout_vld=1 with dout_rdy=1 in this cycle): dout <= completed word, dout_vld <= 1, frame_cnt++.
    - Output slot not free: frame dropped, overrun <= 1, dout unchanged, frame_cnt unchanged.
- Latency: dout_vld is high in the cycle after the edge that samples the last payload bit. The edge that samples the final sync bit counts as bit 0 of the payload count, so the first payload bit is the next valid bit.
- Output handshake:
  - dout and dout_vld are stable while dout_vld=1 and dout_rdy=0.
  - Accept without a new load: dout_vld <= 0 and dout keeps its last value.
  - Accept and load on the same edge: dout_vld stays 1 and dout takes the new word with no bubble.
- sync_lock is a registered decode of state==SHIFT.
- overrun is cleared only by reset.
- frame_cnt is 8-bit modulo.
- dout_rdy is ignored while dout_vld=0.

Decomposition:
- Package serial_deser_pkg holds:
  - state enum {HUNT, SHIFT};
  - default SYNC_PAT and SYNC_W constants;
  - FRAME_CNT_W = 8.
- One sub-module, deser_out_slot: one-entry valid/ready holding register. Inputs: load, load_data, rdy. Outputs: vld, data, full_drop. It owns the free-slot test.
- FSM, window and shift register stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with din_vld=0 for 10 cycles -> all outputs 0, sync_lock=0.
- Basic frame: with dout_rdy=1, send 1,0,1,1 then 0xA5 MSB-first, din_vld=1 throughout -> sync_lock high for 8 cycles, dout_vld=1 for 1 cycle with dout=0xA5, frame_cnt=1.
- Gapped input: same stream with din_vld=0 on every other cycle -> dout=0xA5, delivery delayed accordingly, no extra bits captured.
- Backpressure and overrun:
  - dout_rdy=0; send sync+0x3C, then sync+0xC3 -> dout holds 0x3C, overrun=1, frame_cnt=1.
  - Then raise dout_rdy -> dout_vld falls after one cycle.
- Back-to-back accept: the frame-complete edge coincides with dout_rdy=1 on a held 0x11 while the new word is 0x22 -> dout_vld stays 1 and dout=0x22 the next cycle.
- Reset mid-frame and false sync:
  - rst=0 after 4 payload bits -> state HUNT, dout_vld=0.
  - Stream 1,0,1,0,1,1 -> lock only after the final 1.
  - 256 delivered frames -> frame_cnt wraps to 0.
